// File: rtl/alu_issue_ctrl.sv
// Issue controller between register-file read and write-back. It decodes one MIPS
// instruction per handshake, drives the ALU operands for one cycle, then holds the result.
module alu_issue_ctrl #(
  parameter int DATA_W    = 32,
  parameter int RF_ADDR_W = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 instr_valid,
  output logic                 instr_ready,
  input  logic [31:0]          instr,
  input  logic [DATA_W-1:0]    rs_val,
  input  logic [DATA_W-1:0]    rt_val,
  output logic [DATA_W-1:0]    alu_a,
  output logic [DATA_W-1:0]    alu_b,
  output logic [3:0]           alu_op,
  input  logic [DATA_W-1:0]    alu_result,
  input  logic                 alu_zero,
  output logic                 wb_valid,
  input  logic                 wb_ready,
  output logic [DATA_W-1:0]    wb_data,
  output logic [RF_ADDR_W-1:0] wb_reg,
  output logic                 wb_en,
  output logic                 br_taken,
  output logic                 illegal
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WB} state_t;
  typedef enum logic [1:0] {BR_NONE, BR_EQ, BR_NE} br_kind_t;

  state_t   state;
  br_kind_t br_kind;

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [15:0] imm;
  logic [DATA_W-1:0] imm_sext;
  logic [DATA_W-1:0] imm_zext;

  assign opcode   = instr[31:26];
  assign funct    = instr[5:0];
  assign imm      = instr[15:0];
  assign imm_sext = {{(DATA_W-16){imm[15]}}, imm};
  assign imm_zext = {{(DATA_W-16){1'b0}}, imm};

  // rs index and shamt are not needed here: rs_val arrives already read.
  logic unused_fields;
  assign unused_fields = ^{instr[25:21], instr[10:6]};

  logic [3:0]           dec_op;
  logic [DATA_W-1:0]    dec_b;
  logic [RF_ADDR_W-1:0] dec_reg;
  logic                 dec_en;
  logic                 dec_ill;
  br_kind_t             dec_br;

  always_comb begin
    dec_op  = OP_ADD;
    dec_b   = rt_val;
    dec_reg = instr[20:16];
    dec_en  = 1'b0;
    dec_ill = 1'b0;
    dec_br  = BR_NONE;
    case (opcode)
      6'h00: begin
        dec_reg = instr[15:11];
        dec_en  = 1'b1;
        case (funct)
          6'h20:   dec_op = OP_ADD;
          6'h22:   dec_op = OP_SUB;
          6'h24:   dec_op = OP_AND;
          6'h25:   dec_op = OP_OR;
          6'h27:   dec_op = OP_NOR;
          6'h2A:   dec_op = OP_SLT;
          default: dec_ill = 1'b1;
        endcase
      end
      6'h08: begin dec_op = OP_ADD; dec_b = imm_sext; dec_en = 1'b1; end
      6'h0A: begin dec_op = OP_SLT; dec_b = imm_sext; dec_en = 1'b1; end
      6'h0C: begin dec_op = OP_AND; dec_b = imm_zext; dec_en = 1'b1; end
      6'h0D: begin dec_op = OP_OR;  dec_b = imm_zext; dec_en = 1'b1; end
      6'h23: begin dec_op = OP_ADD; dec_b = imm_sext; dec_en = 1'b1; end
      6'h2B: begin dec_op = OP_ADD; dec_b = imm_sext; dec_en = 1'b0; end
      6'h04: begin dec_op = OP_SUB; dec_br = BR_EQ; end
      6'h05: begin dec_op = OP_SUB; dec_br = BR_NE; end
      default: dec_ill = 1'b1;
    endcase
    // Illegal instructions still present a known-good op so the ALU never sees an undefined code.
    if (dec_ill) begin
      dec_op  = OP_ADD;
      dec_en  = 1'b0;
      dec_br  = BR_NONE;
      dec_reg = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      br_kind     <= BR_NONE;
      instr_ready <= 1'b1;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_op      <= OP_ADD;
      wb_valid    <= 1'b0;
      wb_data     <= '0;
      wb_reg      <= '0;
      wb_en       <= 1'b0;
      br_taken    <= 1'b0;
      illegal     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (instr_valid && instr_ready) begin
            alu_a       <= rs_val;
            alu_b       <= dec_b;
            alu_op      <= dec_op;
            wb_reg      <= dec_reg;
            wb_en       <= dec_en;
            br_kind     <= dec_br;
            illegal     <= dec_ill;
            br_taken    <= 1'b0;
            wb_data     <= '0;
            instr_ready <= 1'b0;
            if (dec_ill) begin
              wb_valid <= 1'b1;
              state    <= S_WB;
            end else begin
              state    <= S_EXEC;
            end
          end
        end
        S_EXEC: begin
          wb_data <= alu_result;
          case (br_kind)
            BR_EQ:   br_taken <= alu_zero;
            BR_NE:   br_taken <= ~alu_zero;
            default: br_taken <= 1'b0;
          endcase
          wb_valid <= 1'b1;
          state    <= S_WB;
        end
        S_WB: begin
          if (wb_ready) begin
            wb_valid    <= 1'b0;
            instr_ready <= 1'b1;
            state       <= S_IDLE;
          end
        end
        default: begin
          state       <= S_IDLE;
          instr_ready <= 1'b1;
          wb_valid    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Multi-cycle issue controller that drives the datapath ALU's operand/op interface (`alu_a`, `alu_b`, `alu_op` out; `alu_result`, `alu_zero` back).
- Accepts one decoded-register instruction per handshake and decodes opcode/funct to the 4-bit ALU op code.
- Selects and extends the second operand, registers the ALU result and zero flag, then presents a write-back/branch record with valid/ready backpressure.
- Sits between register-file read and write-back in the processor core.

Parameters:
- DATA_W, 32, operand/result width; only 32 is supported.
- RF_ADDR_W, 5, register-file address width.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- instr_valid  in  1  instruction record valid.
- instr_ready  out  1  controller can accept; high only in IDLE.
- instr  in  32  MIPS instruction word.
- rs_val  in  DATA_W  value of register rs.
- rt_val  in  DATA_W  value of register rt.
- alu_a  out  DATA_W  ALU first operand (registered).
- alu_b  out  DATA_W  ALU second operand (registered).
- alu_op  out  4  ALU op code (registered).
- alu_result  in  DATA_W  combinational ALU result.
- alu_zero  in  1  combinational ALU zero flag.
- wb_valid  out  1  write-back record valid.
- wb_ready  in  1  consumer accepts record.
- wb_data  out  DATA_W  captured ALU result.
- wb_reg  out  RF_ADDR_W  destination register: rd for R-type, rt for I-type.
- wb_en  out  1  register write required.
- br_taken  out  1  branch condition met (beq/bne).
- illegal  out  1  unsupported instruction.

Behaviour:
- Reset values: all outputs 0 except `alu_op`=0010 (add) and `instr_ready`=1; state = IDLE.
- **Op codes:**
  - and 0000, or 0001, add 0010, sub 0110, slt 0111, nor 1100.
  - The ALU's slt is a signed compare.
  - The ALU result is undefined for any other code, so this block never issues one.
- **Decode, opcode=000000 (R-type), by funct:**
  - 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x27 nor, 0x2A slt.
  - wb_reg=rd, wb_en=1.
- **Decode, I-type:**
  - 0x08 addi: add, imm sign-extended.
  - 0x0A slti: slt, imm sign-extended.
  - 0x0C andi: and, imm zero-extended.
  - 0x0D ori: or, imm zero-extended.
  - 0x23 lw and 0x2B sw: add, imm sign-extended; wb_en=1 for lw, 0 for sw.
  - 0x04 beq and 0x05 bne: sub with b=rt_val; wb_en=0.
  - All other I-type cases: b = extended imm, wb_reg=rt, wb_en=1.
- **Illegal:** any other opcode or funct sets illegal=1, wb_en=0, wb_data=0, br_taken=0.
- **IDLE:**
  - instr_ready=1.
  - On instr_valid & instr_ready: latch decode results into alu_a=rs_val, alu_b, alu_op, wb_reg, wb_en and the branch kind.
  - Next state is EXEC, or WB directly if illegal.
  - ALU outputs hold their last values while idle.
- **EXEC (exactly 1 cycle):**
  - The ALU evaluates the registered operands.
  - At the end of the cycle, capture wb_data=alu_result.
  - br_taken = alu_zero for beq, ~alu_zero for bne, 0 otherwise.
  - Go to WB.
- **WB:**
  - wb_valid=1; all wb_* and br_taken/illegal held stable.
  - On wb_ready=1: go to IDLE and deassert wb_valid on the next cycle.
  - wb_ready is sampled only in WB.
- **Latency:**
  - Accept edge T: EXEC during cycle T+1, wb_valid high from cycle T+2.
  - Minimum issue interval is 3 cycles (2 for illegal).
- instr_valid while not ready is ignored (no acceptance); the producer must hold it.
- Arithmetic is width DATA_W, wrap-around; no overflow trap for add/addi/sub.
- rst=1 in any state (including mid-EXEC or WB with wb_ready low) returns to reset values on that edge. No record is emitted for the aborted instruction.

Test Plan:
- add: instr=0x00853020 (rs=4, rt=5, rd=6), rs_val=5, rt_val=7, wb_ready=1 -> alu_op=0010; wb_valid in cycle T+2 with wb_data=12, wb_reg=6, wb_en=1, br_taken=0.
- slt/slti signed:
  - slt with rs_val=0xFFFFFFFF, rt_val=1 -> wb_data=1.
  - slti with rs=1, imm=0xFFFF -> wb_data=0.
  - addi with rs=1, imm=0xFFFF -> wb_data=0, wb_reg=rt.
- andi zero-extend: rs_val=0xFFFF1234, imm=0xFFFF -> alu_b=0x0000FFFF, wb_data=0x00001234.
- Branches:
  - beq with rs_val=rt_val=9 -> alu_op=0110, br_taken=1, wb_en=0.
  - bne with the same values -> br_taken=0.
  - bne with 9 vs 8 -> br_taken=1.
- Backpressure: wb_ready=0 for 4 cycles in WB -> wb_valid and wb_data stable, instr_ready=0, and a second instr_valid is not accepted. Raising wb_ready -> IDLE next cycle, then the second instruction is accepted.
- Illegal/reset:
  - opcode 0x3F -> WB after 1 cycle, illegal=1, wb_en=0.
  - rst asserted during EXEC -> next cycle instr_ready=1, wb_valid=0, alu_op=0010, and no record is emitted.
